decrypt_scheduler: RTL
======================

Name: decrypt_scheduler

Overview:
- Front-end controller for the decryptor's three engines: caesar (0), scytale (1), zigzag (2).
- Latches the engine select at the first character of a message, forwards characters and the start token to that engine only, then holds off upstream until the engine finishes.
- Merges the three engine output streams into one and passes only the active engine's output.

Parameters:
- D_WIDTH, 8, character width.
- MAX_NOF_CHARS, 50, maximum message length excluding the token.
- START_DECRYPTION_TOKEN, 8'hFA, end-of-message / start-decryption token.
- ACK_TIMEOUT, 4, cycles allowed for the selected engine's busy to rise after the token is forwarded.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- data_i  in  D_WIDTH  upstream character.
- valid_i  in  1  upstream character valid.
- select_i  in  2  engine select: 0 caesar, 1 scytale, 2 zigzag, 3 illegal.
- eng_data_o  out  D_WIDTH  shared character bus to all engines.
- eng_valid_o  out  3  one-hot valid to engines; bit n = engine n.
- eng_busy_i  in  3  engine busy flags.
- eng_data_i  in  3*D_WIDTH  engine outputs; engine n at bits [n*D_WIDTH +: D_WIDTH].
- eng_valid_i  in  3  engine output valids.
- data_o  out  D_WIDTH  merged output character.
- valid_o  out  1  merged output valid.
- busy  out  1  upstream hold-off.
- err_o  out  1  one-cycle error pulse.

Behaviour:
- Reset: all outputs 0, state IDLE, sel register 0, char count 0. Reset mid-operation aborts the current message; engines are not notified.
- Upstream characters are accepted only when valid_i=1 and busy=0. Characters presented while busy=1 are dropped.
- States:
  - IDLE:
    - Accepted non-token character: latch sel=select_i, forward it, count=1, go to STREAM.
    - Accepted token: ignore it (empty message) and pulse err_o.
  - STREAM:
    - Accepted non-token character with count<MAX_NOF_CHARS: forward it, count+1.
    - Accepted non-token character with count==MAX_NOF_CHARS: drop it and pulse err_o. The state is unchanged.
    - Accepted token: forward it, set busy=1 on the next edge, clear the timer, go to WAIT_ACK.
    - select_i changes within STREAM are ignored.
  - WAIT_ACK:
    - eng_busy_i[sel]=1: go to DRAIN.
    - Timer reaches ACK_TIMEOUT: pulse err_o, busy=0, go to IDLE.
  - DRAIN:
    - eng_busy_i[sel] falls to 0: busy=0, count=0, go to IDLE.
    - Upstream may send again in the cycle after busy deasserts.
- Forwarding timing: registered. Character accepted at edge k → eng_data_o and eng_valid_o[sel] valid for exactly one cycle after edge k. eng_data_o holds its value when idle; eng_valid_o otherwise 0.
- Illegal select (sel==3) latched in IDLE:
  - No characters or token are forwarded and eng_valid_o stays 0.
  - err_o pulses once, at the first character.
  - The message is still tracked through STREAM; its token moves straight to IDLE with busy unchanged at 0.
- Output merge: data_o/valid_o = eng_data_i[sel]/eng_valid_i[sel] registered, 1-cycle latency. Valids from non-selected engines are ignored. In IDLE, valid_o=0 and data_o=0.
- busy is high from the cycle after the token is accepted until the cycle after eng_busy_i[sel] falls, or until the timeout.
- Simultaneous events: a token accepted at count==MAX_NOF_CHARS is forwarded normally. An err_o condition and the token in the same cycle give a single err_o pulse.

Optional Feature:
- Macro DECRYPT_SCHED_STATS_EN.
- Defined: adds output ports msg_count_o (16 bits) and drop_count_o (16 bits), both reset to 0 and saturating at 16'hFFFF.
  - msg_count_o increments on each DRAIN→IDLE transition.
  - drop_count_o increments on each character dropped for overflow or busy, and on each character of an illegal-select message.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Caesar message: select 0, chars 8'h41,8'h42 then 8'hFA, engine busy rises 2 cycles after the token and falls 5 cycles later → eng_valid_o=3'b001 for 3 single-cycle pulses with data 41,42,FA; busy high for 8 cycles; valid_o mirrors engine 0 valids one cycle late.
- Select switch: select_i goes 1→2 after the first scytale char → all chars go out on eng_valid_o[1]; eng_valid_i[2]=1 with data 8'h55 does not appear on valid_o.
- Overflow: 51 chars 8'h61 then token, select 2 → 50 forwards, err_o pulses once at char 51, token forwarded.
- Ack timeout: token forwarded, eng_busy_i stays 0 → err_o pulses after 4 cycles, busy returns to 0, a new message is accepted.
- Busy drop and reset: chars sent during DRAIN are not forwarded. rst asserted in DRAIN → next cycle all outputs 0, state IDLE.
- Illegal select 3: chars 8'h30, 8'hFA → eng_valid_o stays 0, one err_o pulse; with DECRYPT_SCHED_STATS_EN, drop_count_o=1 and msg_count_o=0.

Source files
------------

// File: rtl/decrypt_scheduler.sv
// decrypt_scheduler: front-end controller that steers one upstream message to
// one of three decrypt engines (caesar 0, scytale 1, zigzag 2). It holds off
// upstream while that engine works and merges the engine outputs into one stream.
// Latency: character to engine 1 cycle (registered); engine output to data_o 1 cycle.
// Backpressure: busy holds off upstream. Characters offered while busy=1 are dropped.
// Ports: clk/rst (sync, active-high); data_i/valid_i/select_i upstream;
//   eng_data_o/eng_valid_o to engines; eng_busy_i/eng_data_i/eng_valid_i from engines;
//   data_o/valid_o merged output; busy hold-off; err_o one-cycle error pulse.
// Optional: define DECRYPT_SCHED_STATS_EN to add the msg_count_o/drop_count_o counters.
module decrypt_scheduler #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA,
  parameter int                 ACK_TIMEOUT            = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [1:0]           select_i,
  output logic [D_WIDTH-1:0]   eng_data_o,
  output logic [2:0]           eng_valid_o,
  input  logic [2:0]           eng_busy_i,
  input  logic [3*D_WIDTH-1:0] eng_data_i,
  input  logic [2:0]           eng_valid_i,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy,
  output logic                 err_o
`ifdef DECRYPT_SCHED_STATS_EN
  ,
  output logic [15:0]          msg_count_o,
  output logic [15:0]          drop_count_o
`endif
);

  localparam int CW = $clog2(MAX_NOF_CHARS + 1);
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_NOF_CHARS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_STREAM   = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;
  localparam logic [1:0] ST_DRAIN    = 2'd3;

  logic [1:0]         state;
  logic [1:0]         sel;
  logic [CW-1:0]      count;
  logic [TW-1:0]      timer;

  logic               accept;
  logic               is_tok;
  logic               sel_ok;
  logic               new_ok;
  logic               sel_busy;
  logic               sel_vld;
  logic [D_WIDTH-1:0] sel_dat;

  function automatic logic [2:0] onehot(input logic [1:0] s);
    onehot = 3'b001 << s;
  endfunction

  assign accept = valid_i && !busy;
  assign is_tok = (data_i == START_DECRYPTION_TOKEN);
  assign sel_ok = (sel != 2'd3);
  assign new_ok = (select_i != 2'd3);

  // Engine-side view of the latched select; sel==3 maps to "no engine".
  always_comb begin
    sel_busy = 1'b0;
    sel_vld  = 1'b0;
    sel_dat  = '0;
    case (sel)
      2'd0: begin sel_busy = eng_busy_i[0]; sel_vld = eng_valid_i[0]; sel_dat = eng_data_i[0 +: D_WIDTH]; end
      2'd1: begin sel_busy = eng_busy_i[1]; sel_vld = eng_valid_i[1]; sel_dat = eng_data_i[D_WIDTH +: D_WIDTH]; end
      2'd2: begin sel_busy = eng_busy_i[2]; sel_vld = eng_valid_i[2]; sel_dat = eng_data_i[2*D_WIDTH +: D_WIDTH]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      sel         <= 2'd0;
      count       <= '0;
      timer       <= '0;
      busy        <= 1'b0;
      err_o       <= 1'b0;
      eng_data_o  <= '0;
      eng_valid_o <= 3'b000;
      data_o      <= '0;
      valid_o     <= 1'b0;
    end else begin
      eng_valid_o <= 3'b000;
      err_o       <= 1'b0;

      // Merge: only the latched engine, and nothing while idle.
      if (state == ST_IDLE || !sel_ok) begin
        data_o  <= '0;
        valid_o <= 1'b0;
      end else begin
        data_o  <= sel_dat;
        valid_o <= sel_vld;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_tok) begin
              err_o <= 1'b1;                 // empty message
            end else begin
              sel   <= select_i;
              count <= CW'(1);
              state <= ST_STREAM;
              if (new_ok) begin
                eng_data_o  <= data_i;
                eng_valid_o <= onehot(select_i);
              end else begin
                err_o <= 1'b1;               // illegal select: flagged once, here
              end
            end
          end
        end

        ST_STREAM: begin
          if (accept) begin
            if (is_tok) begin
              if (sel_ok) begin
                eng_data_o  <= data_i;
                eng_valid_o <= onehot(sel);
                busy        <= 1'b1;
                timer       <= '0;
                state       <= ST_WAIT_ACK;
              end else begin
                count <= '0;                 // illegal message ends quietly
                state <= ST_IDLE;
              end
            end else if (count != MAX_CNT) begin
              count <= count + CW'(1);
              if (sel_ok) begin
                eng_data_o  <= data_i;
                eng_valid_o <= onehot(sel);
              end
            end else if (sel_ok) begin
              err_o <= 1'b1;                 // overflow; character dropped
            end
          end
        end

        ST_WAIT_ACK: begin
          if (sel_busy) begin
            state <= ST_DRAIN;
          end else if (timer == TIMER_LAST) begin
            err_o <= 1'b1;
            busy  <= 1'b0;
            count <= '0;
            state <= ST_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: begin                       // ST_DRAIN
          if (!sel_busy) begin
            busy  <= 1'b0;
            count <= '0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

`ifdef DECRYPT_SCHED_STATS_EN
  logic drop_evt;
  logic msg_evt;

  // At most one upstream character per cycle, so one drop event at most.
  assign drop_evt = (valid_i && busy) ||
                    (accept && !is_tok && state == ST_IDLE && !new_ok) ||
                    (accept && !is_tok && state == ST_STREAM && (!sel_ok || count == MAX_CNT));
  assign msg_evt  = (state == ST_DRAIN) && !sel_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_count_o  <= '0;
      drop_count_o <= '0;
    end else begin
      if (msg_evt && msg_count_o != 16'hFFFF)
        msg_count_o <= msg_count_o + 16'd1;
      if (drop_evt && drop_count_o != 16'hFFFF)
        drop_count_o <= drop_count_o + 16'd1;
    end
  end
`endif

endmodule
